joy_port_mapper: RTL and testbench
==================================

// Module: joy_port_mapper
// PURPOSE
//  Consumes the two decoded active-low 8-bit pad words produced by the joystick
//  serial decoder and maps each pad onto a Spectrum interface: Kempston, Fuller,
//  Sinclair 1/2 or Cursor keyboard injection.
//  Provides per-pad autofire on fire1, timed in video frames.
//  Holds a ZXUNO config register (JOYCONF) that selects mode and autofire per pad.
// PARAMETERS
//  JOYCONF_ADDR   8'h06  ZXUNO register address of the config register
//  AF_FRAMES      3      frames per autofire half-period (>=1)
//  CONF_RESET     8'h21  config reset value: joy2 = Sinclair1, joy1 = Kempston
// PORTS
//  clk           in   1  system clock; all logic is on this clock
//  rst           in   1  synchronous reset, active-high
//  joy1_n        in   8  pad1 {up,down,left,right,fire1,fire2,fire3,start}, 0 = pressed
//  joy2_n        in   8  pad2, same bit order
//  vsync_pulse   in   1  one-clk strobe per video frame
//  zxuno_addr    in   8  ZXUNO register address
//  zxuno_regrd   in   1  ZXUNO register read strobe
//  zxuno_regwr   in   1  ZXUNO register write strobe
//  din           in   8  CPU write data
//  dout          out  8  register read data
//  oe            out  1  dout valid (drives the CPU bus mux)
//  kbd_addr_hi   in   8  CPU A15..A8 during a keyboard port read
//  kbd_cols_n    out  5  injected key columns, 0 = pressed, ANDed downstream
//  kempston_data out  8  Kempston byte, active-high
//  fuller_data   out  8  Fuller byte, active-low
// BEHAVIOUR
//  Config register conf[7:0]:
//   [3:0] joy1, [7:4] joy2.
//   Per nibble, bit3 = autofire enable; bits[2:0] select the mode:
//   0 off, 1 Kempston, 2 Sinclair1, 3 Sinclair2, 4 Cursor, 5 Fuller, 6/7 off.
//  Register write:
//   zxuno_regwr && addr == JOYCONF_ADDR loads din into conf on that edge.
//  Register read:
//   oe = zxuno_regrd && addr match; dout = conf, combinational.
//   dout = 8'h00 when oe = 0.
//   A read in the same cycle as a write returns the old value.
//  Pipeline:
//   S1 registers joy1_n/joy2_n.
//   S2 registers the effective buttons (autofire applied, inverted to active-high).
//   kempston_data and fuller_data are registered from S2.
//   Input-to-output latency = 3 clks.
//   kbd_cols_n is combinational from S2 and kbd_addr_hi.
//  Autofire (independent per pad):
//   Enable bit clear: fire1 passes through unchanged.
//   Fire1 released: frame counter = 0, phase = 1.
//   Fire1 held: each vsync_pulse increments the counter.
//   When the counter reaches AF_FRAMES-1 on a vsync_pulse, the counter wraps to 0
//   and phase toggles.
//   Effective fire1 = held & phase, so the first frame after a press always fires.
//   Clearing the enable bit mid-burst: fire1 follows the raw input next clk.
//   The counter keeps running.
//  Kempston byte:
//   {start,fire3,fire2,fire1,up,down,left,right}, 1 = pressed.
//   OR of every pad in mode 1; 8'h00 when no pad is in mode 1.
//  Fuller byte:
//   bit7 = ~fire1, bit3 = ~right, bit2 = ~left, bit1 = ~down, bit0 = ~up.
//   Bits 6:4 = 1. AND over pads in mode 5; 8'hFF when none.
//  Key map, row (address bit) -> column:
//   Sinclair1, row A12: left c4, right c3, down c2, up c1, fire1 c0.
//   Sinclair2, row A11: left c0, right c1, down c2, up c3, fire1 c4.
//   Cursor:
//    - row A11: left c4
//    - row A12: down c4, up c3, right c2, fire1 c0
//  kbd_cols_n:
//   A column bit is 0 if any pad maps a pressed button to that column on a row
//   whose kbd_addr_hi bit is 0.
//   Multiple low address bits OR their rows together; 5'h1F when nothing matches.
//  Both pads in the same mode: contributions merge (OR for active-high, AND for
//  active-low).
//  Reset:
//   conf = CONF_RESET; S1/S2 = released.
//   Autofire counters = 0, phase = 1.
//   Outputs: kempston_data = 8'h00, fuller_data = 8'hFF, kbd_cols_n = 5'h1F,
//   dout = 8'h00, oe = 0.
//   Reset mid-burst discards all state; the first output after reset is idle.
// TESTING
//  T1 Reset, joy1_n = 8'h7F (up), conf = 8'h21
//     -> kempston_data = 8'h08 three clks later; fuller_data = 8'hFF.
//  T2 Write 8'h53 to addr 8'h06, joy2_n = 8'hF7 (fire1), kbd_addr_hi = 8'hF7
//     -> Sinclair2 fire on c4: kbd_cols_n = 5'h0F.
//     Read back with regrd -> dout = 8'h53, oe = 1.
//  T3 conf = 8'h09 (joy1 Kempston + autofire, AF_FRAMES = 3), hold fire1 for 12 vsyncs
//     -> bit4 of kempston_data = 1,1,1,0,0,0,1,1,1,0,0,0 per frame.
//     Release mid-burst -> bit4 = 0; re-press -> immediate 1.
//  T4 conf = 8'h44 (both Cursor), joy1 left + joy2 right, kbd_addr_hi = 8'hE7
//     -> kbd_cols_n = 5'h0B.
//     kbd_addr_hi = 8'hFF -> 5'h1F.
//  T5 conf = 8'h05 (joy1 Fuller), joy1_n = 8'hB7 (down + fire1)
//     -> fuller_data = 8'h7D; conf = 8'h00 -> fuller_data = 8'hFF, kempston_data = 8'h00.
//  T6 Assert rst during an autofire burst with regwr active in the same cycle
//     -> conf = 8'h21, all outputs at reset values; the write is ignored.

Source files
------------

// File: rtl/joy_port_mapper.sv
// Maps two decoded active-low joystick pads onto Kempston, Fuller, Sinclair and
// Cursor interfaces, with per-pad frame-timed autofire and a ZXUNO config register.
module joy_port_mapper #(
  parameter logic [7:0]  JOYCONF_ADDR = 8'h06,
  parameter int unsigned AF_FRAMES    = 3,
  parameter logic [7:0]  CONF_RESET   = 8'h21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] joy1_n,
  input  logic [7:0] joy2_n,
  input  logic       vsync_pulse,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  input  logic [7:0] kbd_addr_hi,
  output logic [4:0] kbd_cols_n,
  output logic [7:0] kempston_data,
  output logic [7:0] fuller_data
);

  localparam logic [2:0] MODE_OFF       = 3'd0;
  localparam logic [2:0] MODE_KEMPSTON  = 3'd1;
  localparam logic [2:0] MODE_SINCLAIR1 = 3'd2;
  localparam logic [2:0] MODE_SINCLAIR2 = 3'd3;
  localparam logic [2:0] MODE_CURSOR    = 3'd4;
  localparam logic [2:0] MODE_FULLER    = 3'd5;

  localparam int unsigned B_UP    = 7;
  localparam int unsigned B_DOWN  = 6;
  localparam int unsigned B_LEFT  = 5;
  localparam int unsigned B_RIGHT = 4;
  localparam int unsigned B_FIRE1 = 3;
  localparam int unsigned B_FIRE2 = 2;
  localparam int unsigned B_FIRE3 = 1;
  localparam int unsigned B_START = 0;

  localparam int unsigned        CW     = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
  localparam logic [CW-1:0]      AF_MAX = CW'(AF_FRAMES - 1);

  logic [7:0]         conf;
  logic               conf_sel;
  logic [1:0][2:0]    mode;
  logic [1:0]         af_en;
  logic [1:0][7:0]    s1_n;
  logic [1:0][7:0]    btn_next;
  logic [1:0][7:0]    s2;
  logic [1:0]         held;
  logic [1:0][CW-1:0] af_cnt;
  logic [1:0]         af_phase;
  logic [7:0]         kemp_next;
  logic [7:0]         full_next;
  logic [4:0]         pressed_cols;
  logic               row_a11;
  logic               row_a12;
  logic               unused_addr;

  // ---------------------------------------------------------------- config reg
  assign conf_sel = (zxuno_addr == JOYCONF_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      conf <= CONF_RESET;
    end else if (zxuno_regwr && conf_sel) begin
      conf <= din;
    end
  end

  assign oe   = ~rst & zxuno_regrd & conf_sel;
  assign dout = oe ? conf : '0;

  assign mode[0] = conf[2:0];
  assign mode[1] = conf[6:4];
  assign af_en   = {conf[7], conf[3]};

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_n <= '1;
    end else begin
      s1_n[0] <= joy1_n;
      s1_n[1] <= joy2_n;
    end
  end

  always_comb begin
    held = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      held[p] = ~s1_n[p][B_FIRE1];
    end
  end

  // Autofire keeps counting even with the enable bit clear, so re-enabling
  // mid-hold resumes the running cadence rather than restarting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt   <= '0;
      af_phase <= '1;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (!held[p]) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= 1'b1;
        end else if (vsync_pulse) begin
          if (af_cnt[p] == AF_MAX) begin
            af_cnt[p]   <= '0;
            af_phase[p] <= ~af_phase[p];
          end else begin
            af_cnt[p] <= af_cnt[p] + CW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_comb begin
    btn_next = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      btn_next[p]          = ~s1_n[p];
      btn_next[p][B_FIRE1] = held[p] & (~af_en[p] | af_phase[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2 <= btn_next;
    end
  end

  // ---------------------------------------------------------------- mappings
  function automatic logic [7:0] kemp_bits(input logic [7:0] b);
    return {b[B_START], b[B_FIRE3], b[B_FIRE2], b[B_FIRE1],
            b[B_UP], b[B_DOWN], b[B_LEFT], b[B_RIGHT]};
  endfunction

  function automatic logic [7:0] fuller_bits(input logic [7:0] b);
    return {~b[B_FIRE1], 3'b111, ~b[B_RIGHT], ~b[B_LEFT], ~b[B_DOWN], ~b[B_UP]};
  endfunction

  // Active-high column set for one pad, restricted to the rows being scanned.
  function automatic logic [4:0] key_cols(input logic [2:0] m, input logic [7:0] b,
                                          input logic a11, input logic a12);
    logic [4:0] cols;
    cols = '0;
    case (m)
      MODE_SINCLAIR1: begin
        if (a12) begin
          cols = {b[B_LEFT], b[B_RIGHT], b[B_DOWN], b[B_UP], b[B_FIRE1]};
        end
      end
      MODE_SINCLAIR2: begin
        if (a11) begin
          cols = {b[B_FIRE1], b[B_UP], b[B_DOWN], b[B_RIGHT], b[B_LEFT]};
        end
      end
      MODE_CURSOR: begin
        if (a11) begin
          cols = cols | {b[B_LEFT], 4'b0000};
        end
        if (a12) begin
          cols = cols | {b[B_DOWN], b[B_UP], b[B_RIGHT], 1'b0, b[B_FIRE1]};
        end
      end
      default: cols = '0;
    endcase
    return cols;
  endfunction

  // ---------------------------------------------------------------- outputs
  always_comb begin
    kemp_next = '0;
    full_next = '1;
    for (int unsigned p = 0; p < 2; p++) begin
      if (mode[p] == MODE_KEMPSTON) begin
        kemp_next = kemp_next | kemp_bits(s2[p]);
      end
      if (mode[p] == MODE_FULLER) begin
        full_next = full_next & fuller_bits(s2[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kempston_data <= '0;
      fuller_data   <= '1;
    end else begin
      kempston_data <= kemp_next;
      fuller_data   <= full_next;
    end
  end

  assign row_a11 = ~kbd_addr_hi[3];
  assign row_a12 = ~kbd_addr_hi[4];

  always_comb begin
    pressed_cols = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      pressed_cols = pressed_cols | key_cols(mode[p], s2[p], row_a11, row_a12);
    end
  end

  assign kbd_cols_n = ~pressed_cols;

  assign unused_addr = ^{kbd_addr_hi[7:5], kbd_addr_hi[2:0], MODE_OFF};

endmodule

// File: tb/tb_joy_port_mapper.sv
// Bench for joy_port_mapper: vector table, pipelined Kempston stream, autofire,
// register access and reset-during-burst sequences.
module tb_joy_port_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] joy1_n, joy2_n;
  logic       vsync_pulse;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd, zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;
  logic [7:0] kbd_addr_hi;
  logic [4:0] kbd_cols_n;
  logic [7:0] kempston_data, fuller_data;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] conf, j1, j2, addr, kemp, full;
    logic [4:0] cols;
  } vec_t;

  typedef struct {
    logic [7:0] kemp, full;
    logic [4:0] cols;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  exp_t e;
  logic [7:0] r1, r2;
  int   m_cnt;
  logic m_ph;

  joy_port_mapper #(
    .JOYCONF_ADDR(8'h06),
    .AF_FRAMES(3),
    .CONF_RESET(8'h21)
  ) dut (
    .clk(clk), .rst(rst), .joy1_n(joy1_n), .joy2_n(joy2_n),
    .vsync_pulse(vsync_pulse), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .din(din),
    .dout(dout), .oe(oe), .kbd_addr_hi(kbd_addr_hi), .kbd_cols_n(kbd_cols_n),
    .kempston_data(kempston_data), .fuller_data(fuller_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic wr_conf(input logic [7:0] v);
    @(negedge clk);
    zxuno_addr  = 8'h06;
    din         = v;
    zxuno_regwr = 1'b1;
    @(negedge clk);
    zxuno_regwr = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync_pulse = 1'b1;
    @(negedge clk);
    vsync_pulse = 1'b0;
  endtask

  function automatic logic [7:0] kemp_of(input logic [7:0] jn);
    logic [7:0] b;
    b = ~jn;
    return {b[0], b[1], b[2], b[3], b[7], b[6], b[5], b[4]};
  endfunction

  // Bench-side autofire model, stepped once per vsync while fire1 is held.
  task automatic model_vsync();
    if (m_cnt == 2) begin
      m_cnt = 0;
      m_ph  = ~m_ph;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    vecs[0]  = '{8'h21, 8'h7F, 8'hFF, 8'hFF, 8'h08, 8'hFF, 5'h1F};
    vecs[1]  = '{8'h53, 8'hF7, 8'hF7, 8'hF7, 8'h00, 8'h7F, 5'h0F};
    vecs[2]  = '{8'h44, 8'hDF, 8'hEF, 8'hE7, 8'h00, 8'hFF, 5'h0B};
    vecs[3]  = '{8'h44, 8'hDF, 8'hEF, 8'hFF, 8'h00, 8'hFF, 5'h1F};
    vecs[4]  = '{8'h05, 8'hB7, 8'hFF, 8'h00, 8'h00, 8'h7D, 5'h1F};
    vecs[5]  = '{8'h00, 8'hB7, 8'hFF, 8'h00, 8'h00, 8'hFF, 5'h1F};
    vecs[6]  = '{8'h11, 8'h7F, 8'hFE, 8'hFF, 8'h88, 8'hFF, 5'h1F};
    vecs[7]  = '{8'h55, 8'h7F, 8'hEF, 8'hFF, 8'h00, 8'hF6, 5'h1F};
    vecs[8]  = '{8'h22, 8'hDF, 8'hF7, 8'hEF, 8'h00, 8'hFF, 5'h0E};
    vecs[9]  = '{8'h22, 8'hDF, 8'hF7, 8'hF7, 8'h00, 8'hFF, 5'h1F};
    vecs[10] = '{8'h32, 8'h7F, 8'h7F, 8'hE7, 8'h00, 8'hFF, 5'h15};
    vecs[11] = '{8'h44, 8'h0F, 8'hFF, 8'hEF, 8'h00, 8'hFF, 5'h03};
    vecs[12] = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 5'h1F};
    vecs[13] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'h1F};
    vecs[14] = '{8'h04, 8'hF7, 8'hFF, 8'hEF, 8'h00, 8'hFF, 5'h1E};

    rst = 1'b1; joy1_n = 8'hFF; joy2_n = 8'hFF; vsync_pulse = 1'b0;
    zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0; din = 8'h00;
    kbd_addr_hi = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_kemp", kempston_data, 8'h00);
    chk("rst_full", fuller_data, 8'hFF);
    chk("rst_cols", {3'b0, kbd_cols_n}, 8'h1F);
    chk("rst_dout", dout, 8'h00);
    chk("rst_oe", {7'b0, oe}, 8'h00);
    zxuno_addr = 8'h06; zxuno_regrd = 1'b1; #1;
    chk("rst_conf", dout, 8'h21);
    zxuno_regrd = 1'b0;

    // Table vectors: one transaction at a time through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      wr_conf(vecs[i].conf);
      joy1_n = vecs[i].j1; joy2_n = vecs[i].j2; kbd_addr_hi = vecs[i].addr;
      sb.push_back('{vecs[i].kemp, vecs[i].full, vecs[i].cols});
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_kemp", i), kempston_data, e.kemp);
      chk($sformatf("vec%0d_full", i), fuller_data, e.full);
      chk($sformatf("vec%0d_cols", i), {3'b0, kbd_cols_n}, {3'b0, e.cols});
    end

    // Register access: readback, wrong address, read-during-write.
    wr_conf(8'h53);
    @(negedge clk);
    zxuno_regrd = 1'b1; #1;
    chk("rd_dout", dout, 8'h53);
    chk("rd_oe", {7'b0, oe}, 8'h01);
    zxuno_addr = 8'h07; #1;
    chk("rd_bad_oe", {7'b0, oe}, 8'h00);
    chk("rd_bad_dout", dout, 8'h00);
    zxuno_regwr = 1'b1; din = 8'h00;
    @(negedge clk);
    zxuno_addr = 8'h06; din = 8'hAA; #1;
    chk("rd_bad_wr", dout, 8'h53);
    @(negedge clk);
    zxuno_regwr = 1'b0; #1;
    chk("rd_new", dout, 8'hAA);
    zxuno_regrd = 1'b0;

    // Pipelined stream, both pads Kempston; expected pushed on drive, popped 3 clks later.
    wr_conf(8'h11);
    kbd_addr_hi = 8'h00;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        chk($sformatf("stream%0d_kemp", c), kempston_data, e.kemp);
        chk($sformatf("stream%0d_cols", c), {3'b0, kbd_cols_n}, {3'b0, e.cols});
      end
      if (c < 21) begin
        r1 = 8'($urandom); r2 = 8'($urandom);
      end else begin
        r1 = 8'hFF; r2 = 8'hFF;
      end
      joy1_n = r1; joy2_n = r2;
      sb.push_back('{kemp_of(r1) | kemp_of(r2), 8'hFF, 5'h1F});
    end
    sb.delete();

    // Autofire on pad1 (Kempston, AF_FRAMES = 3).
    wr_conf(8'h09);
    joy1_n = 8'hFF; joy2_n = 8'hFF;
    repeat (4) @(negedge clk);
    joy1_n = 8'hF7; m_cnt = 0; m_ph = 1'b1;
    for (int f = 0; f < 12; f++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("af_frame%0d", f), {7'b0, kempston_data[4]}, {7'b0, m_ph});
      pulse_vsync();
      model_vsync();
    end
    joy1_n = 8'hFF;
    repeat (3) @(negedge clk);
    chk("af_release", {7'b0, kempston_data[4]}, 8'h00);
    joy1_n = 8'hF7; m_cnt = 0; m_ph = 1'b1;
    repeat (3) @(negedge clk);
    chk("af_repress", {7'b0, kempston_data[4]}, 8'h01);
    for (int v = 0; v < 3; v++) begin
      pulse_vsync();
      model_vsync();
    end
    repeat (4) @(negedge clk);
    chk("af_off_phase", {7'b0, kempston_data[4]}, {7'b0, m_ph});
    wr_conf(8'h01);
    repeat (2) @(negedge clk);
    chk("af_disable", kempston_data, 8'h10);

    // Reset during an autofire burst with a simultaneous config write.
    wr_conf(8'h09);
    repeat (4) @(negedge clk);
    for (int v = 0; v < 3; v++) pulse_vsync();
    @(negedge clk);
    rst = 1'b1; zxuno_regwr = 1'b1; zxuno_addr = 8'h06; din = 8'h77;
    @(negedge clk);
    rst = 1'b0; zxuno_regwr = 1'b0;
    chk("rb_kemp", kempston_data, 8'h00);
    chk("rb_full", fuller_data, 8'hFF);
    chk("rb_cols", {3'b0, kbd_cols_n}, 8'h1F);
    chk("rb_dout", dout, 8'h00);
    chk("rb_oe", {7'b0, oe}, 8'h00);
    zxuno_regrd = 1'b1; #1;
    chk("rb_conf", dout, 8'h21);
    zxuno_regrd = 1'b0;
    @(negedge clk);
    chk("rb_first_idle", kempston_data, 8'h00);
    repeat (2) @(negedge clk);
    chk("rb_kemp_fire", kempston_data, 8'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
